// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause 22 MDIO management slave:
// frame state encoding, opcodes and field widths.
package mdio_pkg;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 16;
   localparam int TA_LEN   = 2;
   localparam int SKIP_LEN = TA_LEN + DATA_W;

   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_WRITE = 2'b01;

   typedef enum logic [3:0] {
      IDLE,
      ST2,
      OP,
      PHYAD,
      REGAD,
      TA_R,
      RDATA,
      TA_W,
      WDATA,
      SKIP
   } mdio_state_e;

endpackage

// File: rtl/mdio_regfile.sv
// NUM_REGS x 16-bit register file, one write port, one async read port.
// Ports: clk, rst_n (async low), we/waddr/wdata write, raddr/rdata read.
module mdio_regfile
   import mdio_pkg::*;
#(
   parameter int NUM_REGS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [NUM_REGS];
   logic [DATA_W-1:0] mem_d [NUM_REGS];

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         mem_d[i] = mem_q[i];
         if (we && (waddr == ADDR_W'(i))) begin
            mem_d[i] = wdata;
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (raddr == ADDR_W'(i)) begin
            rdata = mem_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: rtl/mdio_slave_regs.sv
// Clause 22 MDIO slave: decodes frames on data, answers reads, applies writes.
// Ports: clk (MDC), reset (async low), data (MDIO), reg_wr/addr/data, frame_err, busy.
module mdio_slave_regs
   import mdio_pkg::*;
#(
   parameter logic [ADDR_W-1:0] PHY_ADDR     = 5'd1,
   parameter int                NUM_REGS     = 8,
   parameter int                PREAMBLE_LEN = 32
) (
   input  logic              clk,
   input  logic              reset,
   inout  wire               data,
   output logic              reg_wr,
   output logic [ADDR_W-1:0] reg_wr_addr,
   output logic [DATA_W-1:0] reg_wr_data,
   output logic              frame_err,
   output logic              busy
);

   localparam int PW = (PREAMBLE_LEN > 0) ? $clog2(PREAMBLE_LEN + 1) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN);
   localparam logic [ADDR_W:0] NREG_W = (ADDR_W + 1)'(NUM_REGS);

   mdio_state_e state_q, state_d;

   logic [PW-1:0]     pre_q, pre_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] phy_q, phy_d;
   logic [ADDR_W-1:0] regad_q, regad_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              oe_q, oe_d;
   logic              dout_q, dout_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              err_q, err_d;

   logic              din;
   logic [1:0]        op_nx;
   logic [ADDR_W-1:0] regad_nx;
   logic [DATA_W-1:0] wdata_nx;
   logic              rf_we;
   logic [DATA_W-1:0] rf_rdata;
   logic              in_range;
   logic              regad_nx_in_range;

   assign din      = data;
   assign op_nx    = {op_q[0], din};
   assign regad_nx = {regad_q[ADDR_W-2:0], din};
   assign wdata_nx = {sh_q[DATA_W-2:0], din};

   assign in_range          = {1'b0, regad_q} < NREG_W;
   assign regad_nx_in_range = {1'b0, regad_nx} < NREG_W;

   // Read address is the register field including the bit being sampled,
   // so read data is ready to latch on the same edge as the last REGAD bit.
   mdio_regfile #(
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .clk   (clk),
      .rst_n (reset),
      .we    (rf_we),
      .waddr (regad_q),
      .wdata (wdata_nx),
      .raddr (regad_nx),
      .rdata (rf_rdata)
   );

   always_comb begin
      state_d   = state_q;
      pre_d     = pre_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      phy_d     = phy_q;
      regad_d   = regad_q;
      sh_d      = sh_q;
      oe_d      = oe_q;
      dout_d    = dout_q;
      wr_d      = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      err_d     = 1'b0;
      rf_we     = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (din) begin
               if (pre_q < PRE_MAX) begin
                  pre_d = pre_q + 1'b1;
               end
            end else if (pre_q >= PRE_MAX) begin
               pre_d   = '0;
               state_d = ST2;
            end else begin
               pre_d = '0;
            end
         end

         ST2: begin
            if (din) begin
               state_d = OP;
               cnt_d   = '0;
            end else begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end

         OP: begin
            op_d = op_nx;
            if (cnt_q == 5'd1) begin
               cnt_d = '0;
               if ((op_nx == OP_READ) || (op_nx == OP_WRITE)) begin
                  state_d = PHYAD;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end

         PHYAD: begin
            phy_d = {phy_q[ADDR_W-2:0], din};
            if (cnt_q == 5'(ADDR_W - 1)) begin
               cnt_d   = '0;
               state_d = REGAD;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end

         REGAD: begin
            regad_d = regad_nx;
            if (cnt_q == 5'(ADDR_W - 1)) begin
               cnt_d = '0;
               if (phy_q != PHY_ADDR) begin
                  state_d = SKIP;
               end else if (op_q == OP_READ) begin
                  state_d = TA_R;
                  sh_d    = regad_nx_in_range ? rf_rdata : '1;
               end else begin
                  state_d = TA_W;
               end
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end

         // First TA bit leaves the line floating; the second drives 0,
         // and the MSB goes out on the edge that leaves this state.
         TA_R: begin
            if (cnt_q == 5'(TA_LEN - 1)) begin
               cnt_d   = '0;
               dout_d  = sh_q[DATA_W-1];
               sh_d    = {sh_q[DATA_W-2:0], 1'b0};
               state_d = RDATA;
            end else begin
               oe_d   = 1'b1;
               dout_d = 1'b0;
               cnt_d  = cnt_q + 5'd1;
            end
         end

         RDATA: begin
            if (cnt_q == 5'(DATA_W - 1)) begin
               cnt_d   = '0;
               oe_d    = 1'b0;
               dout_d  = 1'b0;
               state_d = IDLE;
            end else begin
               dout_d = sh_q[DATA_W-1];
               sh_d   = {sh_q[DATA_W-2:0], 1'b0};
               cnt_d  = cnt_q + 5'd1;
            end
         end

         TA_W: begin
            if (cnt_q == 5'(TA_LEN - 1)) begin
               cnt_d   = '0;
               state_d = WDATA;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end

         WDATA: begin
            sh_d = wdata_nx;
            if (cnt_q == 5'(DATA_W - 1)) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (in_range) begin
                  rf_we     = 1'b1;
                  wr_d      = 1'b1;
                  wr_addr_d = regad_q;
                  wr_data_d = wdata_nx;
               end
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end

         SKIP: begin
            if (cnt_q == 5'(SKIP_LEN - 1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         pre_q     <= '0;
         cnt_q     <= '0;
         op_q      <= '0;
         phy_q     <= '0;
         regad_q   <= '0;
         sh_q      <= '0;
         oe_q      <= 1'b0;
         dout_q    <= 1'b0;
         wr_q      <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         phy_q     <= phy_d;
         regad_q   <= regad_d;
         sh_q      <= sh_d;
         oe_q      <= oe_d;
         dout_q    <= dout_d;
         wr_q      <= wr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
      end
   end

   assign data        = oe_q ? dout_q : 1'bz;
   assign reg_wr      = wr_q;
   assign reg_wr_addr = wr_addr_q;
   assign reg_wr_data = wr_data_q;
   assign frame_err   = err_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mdio_slave_regs.sv
// Testbench for mdio_slave_regs: random and directed Clause 22 frames
// against a register-array model, checked by scoreboard monitors.
module tb_mdio_slave_regs;

   localparam int NREGS = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic tb_en, d0_en, tb_val, use0;

   wire data;
   wire d0;

   pullup (data);
   pullup (d0);

   assign data = tb_en ? tb_val : 1'bz;
   assign d0   = d0_en ? tb_val : 1'bz;

   logic        reg_wr, frame_err, busy;
   logic [4:0]  reg_wr_addr;
   logic [15:0] reg_wr_data;

   logic        d0_wr, d0_err, busy0;
   logic [4:0]  d0_addr;
   logic [15:0] d0_data;

   mdio_slave_regs #(
      .PHY_ADDR     (5'd1),
      .NUM_REGS     (NREGS),
      .PREAMBLE_LEN (32)
   ) dut (
      .clk         (clk),
      .reset       (rst_n),
      .data        (data),
      .reg_wr      (reg_wr),
      .reg_wr_addr (reg_wr_addr),
      .reg_wr_data (reg_wr_data),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   mdio_slave_regs #(
      .PHY_ADDR     (5'd1),
      .NUM_REGS     (NREGS),
      .PREAMBLE_LEN (0)
   ) dut0 (
      .clk         (clk),
      .reset       (rst_n),
      .data        (d0),
      .reg_wr      (d0_wr),
      .reg_wr_addr (d0_addr),
      .reg_wr_data (d0_data),
      .frame_err   (d0_err),
      .busy        (busy0)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [15:0] model [32];
   logic [20:0] wr_q [$];
   logic [15:0] rd_q [$];
   int          err_exp = 0;
   event        rd_go;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic release_line();
      tb_en = 1'b0;
      d0_en = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      tb_val = b;
      if (use0) d0_en = 1'b1;
      else tb_en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic preamble(input int n);
      repeat (n) send_bit(1'b1);
   endtask

   task automatic header(input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] ra);
      send_bit(1'b0);
      chk("busy_at_start", 32'(use0 ? busy0 : busy), 32'd1);
      send_bit(1'b1);
      send_bits({14'd0, op}, 2);
      send_bits({11'd0, phy}, 5);
      send_bits({11'd0, ra}, 5);
   endtask

   task automatic do_write(input logic [4:0] phy, input logic [4:0] ra,
                           input logic [15:0] wd);
      preamble(32);
      header(2'b01, phy, ra);
      if (phy == 5'd1 && ra < 5'(NREGS)) begin
         wr_q.push_back({ra, wd});
         model[ra] = wd;
      end
      send_bits(16'h0002, 2);
      send_bits(wd, 16);
      release_line();
   endtask

   task automatic do_read(input logic [4:0] phy, input logic [4:0] ra);
      preamble(32);
      header(2'b10, phy, ra);
      release_line();
      if (phy == 5'd1) begin
         rd_q.push_back(ra < 5'(NREGS) ? model[ra] : 16'hFFFF);
         ->rd_go;
         repeat (19) @(negedge clk);
         chk("busy_after_read", 32'(busy), 32'd0);
         #1;
      end else begin
         for (int n = 0; n < 18; n++) begin
            @(negedge clk);
            chk("skip_busy", 32'(busy), 32'd1);
            chk("skip_line_free", 32'(data), 32'd1);
         end
         @(negedge clk);
         chk("skip_busy_end", 32'(busy), 32'd0);
      end
   endtask

   // read data monitor: TA, 16 data bits, release
   initial begin
      logic [18:0] s;
      logic [15:0] w;
      logic [15:0] e;
      forever begin
         @(rd_go);
         for (int n = 0; n < 19; n++) begin
            @(negedge clk);
            s[n] = data;
         end
         for (int n = 2; n < 18; n++) w[17 - n] = s[n];
         if (rd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rd_unexpected: got %0h expected none", w);
         end else begin
            e = rd_q.pop_front();
            chk("rd_ta1_float", 32'(s[0]), 32'd1);
            chk("rd_ta2_zero", 32'(s[1]), 32'd0);
            chk("rd_word", 32'(w), 32'(e));
            chk("rd_release", 32'(s[18]), 32'd1);
         end
      end
   end

   // pulse monitor: reg_wr and frame_err
   initial begin
      logic [20:0] e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (reg_wr === 1'b1) begin
               if (wr_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL wr_unexpected: got addr %0h data %0h expected none",
                           reg_wr_addr, reg_wr_data);
               end else begin
                  e = wr_q.pop_front();
                  chk("wr_addr", 32'(reg_wr_addr), 32'(e[20:16]));
                  chk("wr_data", 32'(reg_wr_data), 32'(e[15:0]));
               end
            end
            if (frame_err === 1'b1) begin
               if (err_exp == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL err_unexpected: got 1 expected 0");
               end else begin
                  err_exp--;
               end
            end
         end
      end
   end

   initial begin
      logic       seen;
      logic [4:0] ra, phy;
      rst_n  = 1'b0;
      tb_en  = 1'b0;
      d0_en  = 1'b0;
      tb_val = 1'b1;
      use0   = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 16'h0000;

      repeat (3) @(negedge clk);
      chk("rst_reg_wr", 32'(reg_wr), 32'd0);
      chk("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
      chk("rst_wr_data", 32'(reg_wr_data), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_line_free", 32'(data), 32'd1);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_line_free", 32'(data), 32'd1);
      #1;

      do_write(5'd1, 5'd3, 16'hA5C3);
      do_read(5'd1, 5'd3);
      do_read(5'd1, 5'd20);
      do_write(5'd1, 5'd20, 16'h1234);
      do_read(5'd2, 5'd3);
      do_write(5'd1, 5'd4, 16'h0F0E);
      do_read(5'd1, 5'd4);

      // short preamble straight after a frame end: must be ignored
      do_write(5'd1, 5'd6, 16'h7777);
      seen = 1'b0;
      for (int i = 0; i < 31; i++) begin
         send_bit(1'b1);
         seen |= busy;
      end
      for (int i = 0; i < 14; i++) begin
         send_bit(i == 1 || i == 3 || i == 8 ? 1'b1 : 1'b0);
         seen |= busy;
      end
      for (int i = 0; i < 18; i++) begin
         send_bit(i == 0 ? 1'b1 : 1'b0);
         seen |= busy;
      end
      release_line();
      chk("short_pre_no_busy", 32'(seen), 32'd0);
      do_read(5'd1, 5'd6);

      // bad opcode and bad start
      preamble(32);
      err_exp++;
      send_bits(16'h0007, 4);
      release_line();
      repeat (3) @(posedge clk);
      #1;
      preamble(32);
      err_exp++;
      send_bits(16'h0000, 2);
      release_line();
      repeat (3) @(posedge clk);
      #1;

      // preamble suppression instance
      use0 = 1'b1;
      header(2'b01, 5'd1, 5'd2);
      send_bits(16'h0002, 2);
      send_bits(16'h3C5A, 16);
      chk("nopre_wr", 32'(d0_wr), 32'd1);
      chk("nopre_addr", 32'(d0_addr), 32'd2);
      chk("nopre_data", 32'(d0_data), 32'h3C5A);
      release_line();
      use0 = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int k = 0; k < 24; k++) begin
         ra  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31))
                                           : 5'($urandom_range(0, 7));
         phy = ($urandom_range(0, 5) == 0) ? 5'd9 : 5'd1;
         if ($urandom_range(0, 1) == 1) do_write(phy, ra, 16'($urandom));
         else do_read(phy, ra);
      end

      // reset in the middle of read data
      do_write(5'd1, 5'd5, 16'h1234);
      preamble(32);
      header(2'b10, 5'd1, 5'd5);
      release_line();
      repeat (10) @(posedge clk);
      #1;
      chk("mid_rd_bit7", 32'(data), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_line_free", 32'(data), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 32; i++) model[i] = 16'h0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      do_read(5'd1, 5'd5);
      do_read(5'd1, 5'd3);

      repeat (5) @(negedge clk);
      chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);
      chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
      chk("err_all_seen", 32'(err_exp), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
